// File: rtl/vpu_pkg.sv
// Shared widths, saturation bounds and word/keep types for the VPU requant packer.
package vpu_pkg;
    localparam int ACCUM_WIDTH = 48;
    localparam int OUT_WIDTH   = 8;
    localparam int PACK        = 4;
    localparam int LANE_W      = $clog2(PACK);
    localparam int SAT_MAX     = 127;
    localparam int SAT_MIN     = -128;

    typedef logic [PACK*OUT_WIDTH-1:0] word_t;
    typedef logic [PACK-1:0]           keep_t;
endpackage

// File: rtl/vpu_sync_fifo.sv
// Small synchronous FIFO; read data comes straight from the storage registers and reads 0 when empty.
module vpu_sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the head slot, so a push into a full FIFO is still accepted.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/vpu_requant_packer.sv
// Requantizes VPU accumulator results to int8 and packs four lanes per output word.
// Optional saturation statistics counter enabled with VPU_PACK_STATS_EN.
module vpu_requant_packer
    import vpu_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SHIFT_WIDTH = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [ACCUM_WIDTH-1:0] accum_in,
    input  logic                          accum_done,
    input  logic [SHIFT_WIDTH-1:0]        shift_amt,
    input  logic                          relu_en,
    input  logic                          flush,
    output logic [PACK*OUT_WIDTH-1:0]     out_data,
    output logic [PACK-1:0]               out_keep,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow_err,
    output logic [15:0]                   sat_count
);
    localparam logic [SHIFT_WIDTH-1:0] SHIFT_MAX = SHIFT_WIDTH'(ACCUM_WIDTH - 1);

    function automatic logic signed [ACCUM_WIDTH:0] round_shift(
        input logic signed [ACCUM_WIDTH-1:0] acc,
        input logic [SHIFT_WIDTH-1:0]        sh
    );
        logic signed [ACCUM_WIDTH:0] half;
        logic signed [ACCUM_WIDTH:0] sum;
        half = '0;
        if (sh != '0) half[sh - 1'b1] = 1'b1;
        sum = {acc[ACCUM_WIDTH-1], acc} + half;
        return sum >>> sh;
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [ACCUM_WIDTH:0] r);
        if (r > SAT_MAX)      return OUT_WIDTH'(SAT_MAX);
        else if (r < SAT_MIN) return OUT_WIDTH'(SAT_MIN);
        else                  return r[OUT_WIDTH-1:0];
    endfunction

    logic                          done_q;
    logic                          capture;
    logic signed [ACCUM_WIDTH-1:0] acc_p1;
    logic [SHIFT_WIDTH-1:0]        shift_p1;
    logic                          relu_p1;
    logic                          vld_p1;
    logic                          flush_p1;
    logic signed [ACCUM_WIDTH:0]   rq_p1;
    logic signed [OUT_WIDTH-1:0]   lane_p1;
    logic [PACK-1:0][OUT_WIDTH-1:0] word_q;
    logic [PACK-1:0][OUT_WIDTH-1:0] wr_word;
    keep_t                         keep_q;
    keep_t                         wr_keep;
    logic [LANE_W-1:0]             lane_idx;
    logic                          word_push;
    logic                          fifo_pop;
    logic                          fifo_full;
    logic                          fifo_empty;

    assign capture = accum_done && !done_q;

    // S1: capture on the rising edge of done; flush rides alongside
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q   <= 1'b0;
            vld_p1   <= 1'b0;
            flush_p1 <= 1'b0;
        end else begin
            done_q   <= accum_done;
            vld_p1   <= capture;
            flush_p1 <= flush;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            acc_p1   <= accum_in;
            shift_p1 <= (shift_amt >= SHIFT_MAX) ? SHIFT_MAX : shift_amt;
            relu_p1  <= relu_en;
        end
    end

    // S2: requantize, then pack into the current word
    always_comb begin
        rq_p1 = round_shift(acc_p1, shift_p1);
        if (relu_p1 && rq_p1 < 0) rq_p1 = '0;
        lane_p1 = saturate(rq_p1);
    end

    always_comb begin
        wr_word = word_q;
        wr_keep = keep_q;
        if (vld_p1) begin
            wr_word[lane_idx] = lane_p1;
            wr_keep[lane_idx] = 1'b1;
        end
        word_push = (vld_p1 && lane_idx == LANE_W'(PACK - 1)) || (flush_p1 && wr_keep != '0);
    end

    always_ff @(posedge clk) begin
        if (rst || word_push) begin
            word_q   <= '0;
            keep_q   <= '0;
            lane_idx <= '0;
        end else if (vld_p1) begin
            word_q   <= wr_word;
            keep_q   <= wr_keep;
            lane_idx <= lane_idx + 1'b1;
        end
    end

    assign fifo_pop  = out_valid && out_ready;
    assign out_valid = !fifo_empty;

    vpu_sync_fifo #(
        .WIDTH(PACK*OUT_WIDTH + PACK),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (word_push),
        .push_data({wr_keep, word_t'(wr_word)}),
        .pop      (fifo_pop),
        .pop_data ({out_keep, out_data}),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst)                                      overflow_err <= 1'b0;
        else if (word_push && fifo_full && !fifo_pop) overflow_err <= 1'b1;
    end

`ifdef VPU_PACK_STATS_EN
    logic        lane_sat;
    logic [15:0] sat_cnt;

    assign lane_sat = (rq_p1 > SAT_MAX) || (rq_p1 < SAT_MIN);

    always_ff @(posedge clk) begin
        if (rst)                                          sat_cnt <= '0;
        else if (vld_p1 && lane_sat && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 1'b1;
    end

    assign sat_count = sat_cnt;
`else
    assign sat_count = '0;
`endif
endmodule

// File: tb/tb_vpu_requant_packer.sv
// Table-driven bench with a word scoreboard for vpu_requant_packer.
module tb_vpu_requant_packer;
    logic               clk;
    logic               rst;
    logic signed [47:0] accum_in;
    logic               accum_done;
    logic [5:0]         shift_amt;
    logic               relu_en;
    logic               flush;
    logic [31:0]        out_data;
    logic [3:0]         out_keep;
    logic               out_valid;
    logic               out_ready;
    logic               overflow_err;
    logic [15:0]        sat_count;

    vpu_requant_packer dut (
        .clk         (clk),
        .rst         (rst),
        .accum_in    (accum_in),
        .accum_done  (accum_done),
        .shift_amt   (shift_amt),
        .relu_en     (relu_en),
        .flush       (flush),
        .out_data    (out_data),
        .out_keep    (out_keep),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overflow_err(overflow_err),
        .sat_count   (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [47:0] acc;
        logic [5:0]         sh;
        logic               relu;
        logic [7:0]         exp;
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
    } exp_t;

    vec_t tbl [12];
    exp_t sbq [$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One clock: scoreboard check at the falling edge, then step to just after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word actual=%h/%b required=none", out_data, out_keep);
            end else begin
                e = sbq.pop_front();
                chk("word_data", out_data, e.data);
                chk("word_keep", 32'(out_keep), 32'(e.keep));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic signed [47:0] a, input logic [5:0] s, input logic r, input logic f);
        accum_in   = a;
        shift_amt  = s;
        relu_en    = r;
        accum_done = 1'b1;
        flush      = f;
        tick();
        accum_done = 1'b0;
        flush      = 1'b0;
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sbq.size() != 0; i++) tick();
        chk("drain_done", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        exp_t w;
        tbl[0]  = '{48'sd300,              6'd2,  1'b0, 8'h4B};
        tbl[1]  = '{48'sd6,                6'd2,  1'b0, 8'h02};
        tbl[2]  = '{-48'sd6,               6'd2,  1'b0, 8'hFF};
        tbl[3]  = '{48'sd1000,             6'd2,  1'b0, 8'h7F};
        tbl[4]  = '{-48'sd1000,            6'd2,  1'b0, 8'h80};
        tbl[5]  = '{-48'sd1000,            6'd2,  1'b1, 8'h00};
        tbl[6]  = '{48'sd5,                6'd1,  1'b0, 8'h03};
        tbl[7]  = '{-48'sd5,               6'd1,  1'b0, 8'hFE};
        tbl[8]  = '{48'sh7FFF_FFFF_FFFF,   6'd63, 1'b0, 8'h01};
        tbl[9]  = '{48'sh8000_0000_0000,   6'd63, 1'b0, 8'hFF};
        tbl[10] = '{-48'sd128,             6'd0,  1'b0, 8'h80};
        tbl[11] = '{48'sd127,              6'd0,  1'b0, 8'h7F};

        rst = 1'b1; accum_in = '0; accum_done = 1'b0; shift_amt = '0;
        relu_en = 1'b0; flush = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_keep", 32'(out_keep), 32'd0);
        chk("rst_overflow", 32'(overflow_err), 32'd0);
        chk("rst_sat_count", 32'(sat_count), 32'd0);

        // Table vectors: three full words; the first word also checks the two-cycle latency.
        w = '0;
        for (int i = 0; i < 12; i++) begin
            w.data[(i%4)*8 +: 8] = tbl[i].exp;
            w.keep[i%4]          = 1'b1;
            if (i % 4 == 3) sbq.push_back(w);
            if (i == 3) begin
                accum_in = tbl[i].acc; shift_amt = tbl[i].sh; relu_en = tbl[i].relu;
                accum_done = 1'b1;
                tick();
                accum_done = 1'b0;
                chk("latency_n1_valid", 32'(out_valid), 32'd0);
                tick();
                chk("latency_n2_valid", 32'(out_valid), 32'd1);
                chk("latency_n2_data", out_data, 32'h7FFF024B);
            end else begin
                capture(tbl[i].acc, tbl[i].sh, tbl[i].relu, 1'b0);
            end
            if (i % 4 == 3) w = '0;
        end
        drain();
`ifdef VPU_PACK_STATS_EN
        chk("sat_count_table", 32'(sat_count), 32'd2);
`else
        chk("sat_count_table", 32'(sat_count), 32'd0);
`endif

        // Done held high: a single lane, emitted by a later flush.
        accum_in = 48'sd40; shift_amt = 6'd0; relu_en = 1'b0; accum_done = 1'b1;
        repeat (10) tick();
        accum_done = 1'b0;
        tick(); tick();
        chk("held_done_no_word", 32'(out_valid), 32'd0);
        sbq.push_back('{32'h0000_0028, 4'b0001});
        flush = 1'b1; tick(); flush = 1'b0;
        drain();

        // Flush together with the second capture, then a flush with nothing pending.
        capture(48'sd10, 6'd0, 1'b0, 1'b0);
        sbq.push_back('{32'h0000_140A, 4'b0011});
        capture(48'sd20, 6'd0, 1'b0, 1'b1);
        drain();
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (5) tick();
        chk("empty_flush_no_word", 32'(out_valid), 32'd0);

        // Back-pressure: five words into a four-entry FIFO.
        chk("pre_overflow", 32'(overflow_err), 32'd0);
        out_ready = 1'b0;
        for (int wi = 0; wi < 5; wi++) begin
            w = '0;
            for (int l = 0; l < 4; l++) begin
                w.data[l*8 +: 8] = 8'(wi*4 + l + 1);
                w.keep[l]        = 1'b1;
                capture(48'(wi*4 + l + 1), 6'd0, 1'b0, 1'b0);
            end
            if (wi < 4) sbq.push_back(w);
        end
        tick();
        chk("overflow_set", 32'(overflow_err), 32'd1);
        chk("overflow_full_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        drain();
        chk("overflow_sticky", 32'(overflow_err), 32'd1);
        chk("overflow_drained", 32'(out_valid), 32'd0);

        // Reset with three lanes pending discards them.
        capture(48'sd50, 6'd0, 1'b0, 1'b0);
        capture(48'sd51, 6'd0, 1'b0, 1'b0);
        capture(48'sd52, 6'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_keep", 32'(out_keep), 32'd0);
        chk("midrst_overflow", 32'(overflow_err), 32'd0);
        chk("midrst_sat_count", 32'(sat_count), 32'd0);
        sbq.push_back('{32'h3F3E_3D3C, 4'b1111});
        capture(48'sd60, 6'd0, 1'b0, 1'b0);
        capture(48'sd61, 6'd0, 1'b0, 1'b0);
        capture(48'sd62, 6'd0, 1'b0, 1'b0);
        capture(48'sd63, 6'd0, 1'b0, 1'b0);
        drain();
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
